// File: rtl/jump_pkg.sv
// Shared state type, default parameters and arc-width helper for the Dino jump engine.
// Optional macro VARIABLE_JUMP_EN: releasing the button mid-rise cuts the arc short.
package jump_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    AIR      = 2'd1,
    COOLDOWN = 2'd2
  } jump_state_t;

  localparam int TICK_DIV_DEF        = 1_350_000;
  localparam int DEBOUNCE_CYCLES_DEF = 270_000;
  localparam int HEIGHT_W_DEF        = 6;
  localparam int MAX_HEIGHT_DEF      = 20;
  localparam int V0_DEF              = 5;
  localparam int GRAVITY_DEF         = 1;
  localparam int COOLDOWN_TICKS_DEF  = 3;

  // Sign bit plus one overflow bit so height+vel never wraps before clamping.
  localparam int ARC_PAD = 2;

  function automatic int arc_w(input int hw);
    return hw + ARC_PAD;
  endfunction

endpackage

// File: rtl/jump_arc_if.sv
// Button/game inputs and jump outputs between the board glue and the jump engine.
interface jump_arc_if #(
  parameter int HEIGHT_W = 6
);
  logic                btn_n;
  logic                game_run;
  logic [HEIGHT_W-1:0] jump_height;
  logic                airborne;
  logic                jump_start;
  logic                land;

  modport master (
    output btn_n, game_run,
    input  jump_height, airborne, jump_start, land
  );

  modport slave (
    input  btn_n, game_run,
    output jump_height, airborne, jump_start, land
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and stable-count debouncer for an active-low raw button.
module btn_debounce
  import jump_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed_db,
  output logic press_evt,
  output logic rel_evt
);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [DW-1:0] cnt;
  logic          pressed_sync;

  assign pressed_sync = ~sync_q[1];

  // Counter tracks consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      cnt        <= '0;
      pressed_db <= 1'b0;
      press_evt  <= 1'b0;
      rel_evt    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_n};
      press_evt <= 1'b0;
      rel_evt   <= 1'b0;
      if (pressed_sync == pressed_db) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt        <= '0;
        pressed_db <= pressed_sync;
        press_evt  <= pressed_sync;
        rel_evt    <= ~pressed_sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jump_arc_controller.sv
// Dino jump engine: debounced edge-triggered jump, gravity arc per physics tick, landing cooldown.
// Optional macro VARIABLE_JUMP_EN: a release while rising zeroes velocity for short hops.
module jump_arc_controller
  import jump_pkg::*;
#(
  parameter int TICK_DIV        = TICK_DIV_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HEIGHT_W        = HEIGHT_W_DEF,
  parameter int MAX_HEIGHT      = MAX_HEIGHT_DEF,
  parameter int V0              = V0_DEF,
  parameter int GRAVITY         = GRAVITY_DEF,
  parameter int COOLDOWN_TICKS  = COOLDOWN_TICKS_DEF
) (
  input logic       clk,
  input logic       rst,
  jump_arc_if.slave bus
);
  localparam int SW = arc_w(HEIGHT_W);
  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;

  localparam logic signed [SW-1:0] VEL_0   = SW'(V0);
  localparam logic signed [SW-1:0] VEL_G   = SW'(GRAVITY);
  localparam logic signed [SW-1:0] VEL_MIN = SW'(-MAX_HEIGHT);
  localparam logic signed [SW-1:0] H_MAX   = SW'(MAX_HEIGHT);
  localparam logic [TW-1:0]        TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0]        CD_LAST   = CW'(COOLDOWN_TICKS - 1);

  logic pressed_db, press_evt, rel_evt;
  logic unused_db;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (bus.btn_n),
    .pressed_db (pressed_db),
    .press_evt  (press_evt),
    .rel_evt    (rel_evt)
  );

  assign unused_db = pressed_db ^ rel_evt;

  // Free-running physics tick; never paused by state or game_run.
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  jump_state_t          state;
  logic signed [SW-1:0] vel;
  logic [HEIGHT_W-1:0]  height;
  logic [CW-1:0]        cd_cnt;
  logic                 airborne, jump_start, land;

  logic signed [SW-1:0] vel_cur, vel_dec, vel_next, h_next;
  logic                 h_ground, h_over;

  always_comb begin
    vel_cur = vel;
`ifdef VARIABLE_JUMP_EN
    if (rel_evt && !vel[SW-1] && (vel != '0)) vel_cur = '0;
`endif
    h_next   = $signed({{ARC_PAD{1'b0}}, height}) + vel_cur;
    vel_dec  = vel_cur - VEL_G;
    vel_next = (vel_dec < VEL_MIN) ? VEL_MIN : vel_dec;
    h_ground = h_next[SW-1] || (h_next == '0);
    h_over   = (h_next > H_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vel        <= '0;
      height     <= '0;
      cd_cnt     <= '0;
      airborne   <= 1'b0;
      jump_start <= 1'b0;
      land       <= 1'b0;
    end else begin
      jump_start <= 1'b0;
      land       <= 1'b0;
      if (!bus.game_run) begin
        state    <= IDLE;
        vel      <= '0;
        height   <= '0;
        cd_cnt   <= '0;
        airborne <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (press_evt) begin
              state      <= AIR;
              vel        <= VEL_0;
              height     <= '0;
              jump_start <= 1'b1;
              airborne   <= 1'b1;
            end
          end
          AIR: begin
            // The tick overlapping the launch cycle is skipped so the arc starts cleanly.
            if (tick && !jump_start) begin
              if (h_ground) begin
                state    <= COOLDOWN;
                height   <= '0;
                vel      <= '0;
                cd_cnt   <= '0;
                land     <= 1'b1;
                airborne <= 1'b0;
              end else begin
                vel    <= vel_next;
                height <= h_over ? HEIGHT_W'(MAX_HEIGHT) : h_next[HEIGHT_W-1:0];
              end
            end
`ifdef VARIABLE_JUMP_EN
            else begin
              vel <= vel_cur;
            end
`endif
          end
          COOLDOWN: begin
            if (COOLDOWN_TICKS == 0) begin
              state <= IDLE;
            end else if (tick) begin
              if (cd_cnt == CD_LAST) begin
                state  <= IDLE;
                cd_cnt <= '0;
              end else begin
                cd_cnt <= cd_cnt + 1'b1;
              end
            end
          end
          default: begin
            state    <= IDLE;
            airborne <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.jump_height = height;
  assign bus.airborne    = airborne;
  assign bus.jump_start  = jump_start;
  assign bus.land        = land;

endmodule

// File: doc/jump_arc_controller.md
Name: jump_arc_controller

Overview:
Next-generation Dino jump engine. It replaces the single-bit fixed-duration jump flag with a multi-bit vertical height that follows a gravity arc. Includes button synchronisation and debounce, edge-triggered jump start, a landing cooldown, and a game-run gate. Sits between the raw board button and the sprite/collision logic, which consume jump_height in pixels.

Parameters:
TICK_DIV, 1_350_000, clk cycles per physics tick (20 Hz at 27 MHz); must be >= 2
DEBOUNCE_CYCLES, 270_000, consecutive stable synced samples needed to accept a button change (10 ms)
HEIGHT_W, 6, width of jump_height
MAX_HEIGHT, 20, height ceiling in pixels; must be < 2**HEIGHT_W
V0, 5, initial upward velocity in pixels/tick; 1..MAX_HEIGHT
GRAVITY, 1, velocity decrement per tick; >= 1
COOLDOWN_TICKS, 3, ticks spent grounded after landing before a new jump is accepted

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_n  in  1  raw button, active-low, asynchronous to clk
game_run  in  1  high while the game is running; low aborts and blocks jumps
jump_height  out  HEIGHT_W  current height above ground, unsigned pixels
airborne  out  1  high in AIR state
jump_start  out  1  one-cycle pulse when a jump begins
land  out  1  one-cycle pulse when the arc returns to ground

Behaviour:
- Reset: jump_height=0, airborne=0, jump_start=0, land=0, state=IDLE, vel=0, tick counter=0, debounced level = released, sync flops = released (1).
- Input path: 2-FF synchroniser on btn_n, then debounce. pressed_db flips only after the synced value differs from pressed_db for DEBOUNCE_CYCLES consecutive cycles; the counter clears on any agreeing sample. press_evt = one-cycle pulse on the pressed_db 0->1 transition; rel_evt = 1->0.
- Tick: free-running counter 0..TICK_DIV-1 that wraps. tick is high in the cycle the counter equals TICK_DIV-1. The counter never pauses.
- States: IDLE, AIR, COOLDOWN.
- IDLE: press_evt && game_run moves to AIR next cycle, with vel=V0, height=0, and jump_start high for that one cycle. Jumps are edge-triggered; holding the button never re-triggers.
- AIR, on each tick:
  - h_next = height + vel, computed signed at HEIGHT_W+2 bits.
  - vel_next = vel - GRAVITY, saturating at -MAX_HEIGHT.
  - If h_next > MAX_HEIGHT, height = MAX_HEIGHT (vel still decrements).
  - If h_next <= 0, height = 0, state = COOLDOWN, and land is high for one cycle.
  - Height is unchanged between ticks.
- COOLDOWN: counts COOLDOWN_TICKS ticks, then returns to IDLE. press_evt during COOLDOWN is dropped, not queued. COOLDOWN_TICKS=0 returns to IDLE on the cycle after land.
- First height update is on the first tick strictly after the jump_start cycle. A tick coincident with jump_start does not advance the arc.
- game_run low in any state: next cycle goes to IDLE, height=0, vel=0, cooldown cleared. No land pulse. Overrides a coincident tick or press_evt.
- airborne is registered and equals (state==AIR).
- Async rst mid-jump returns everything to reset values immediately. The button must be released and re-pressed (debounced) to jump again.

Optional Feature:
VARIABLE_JUMP_EN
- Defined: rel_evt while in AIR with vel > 0 sets vel=0 on the next cycle, so the arc apexes at the current height and falls. This gives short hops on taps.
- Not defined: release is ignored and every jump follows the full V0 arc.

Decomposition:
- Package jump_pkg: state enum (IDLE/AIR/COOLDOWN), default parameter constants, and the localparam for the signed internal width (HEIGHT_W+2).
- Sub-module btn_debounce(clk, rst, btn_n, pressed_db, press_evt, rel_evt), parameterised by DEBOUNCE_CYCLES, containing the synchroniser and debounce counter.
- Tick divider and arc FSM stay in jump_arc_controller.

Test Plan:
- Arc shape (TICK_DIV=4, DEBOUNCE=3, V0=3, G=1, MAX=63, CD=2): a clean press yields jump_start once, then per-tick heights 3,5,6,6,5,3,0 with land on the 0 tick, then IDLE after 2 ticks.
- Clamp (same, MAX=4): per-tick heights 3,4,4,4,3,1,0; jump_height never exceeds 4.
- Bounce: btn_n toggling every 2 cycles for 20 cycles produces no press_evt. A subsequent steady low gives jump_start exactly 2+3+1 cycles after the low edge.
- Hold/cooldown: button held through the whole arc gives exactly one jump_start. A press during COOLDOWN gives no jump. A release then press after COOLDOWN starts a new jump.
- Abort: game_run dropped at height 5 gives height 0 and airborne 0 the next cycle, no land pulse. A press while game_run=0 is ignored.
- Reset and option: rst asserted mid-AIR clears all outputs asynchronously. With VARIABLE_JUMP_EN, a release after the first tick (height 3) gives heights 3,3,2,0 (vel 0,-1,-2,-3).
